hex_display_scanner: RTL and testbench

- Downstream display stage for the 4-bit counter value (q).
- Shifts incoming 4-bit nibbles into a NUM_DIGITS-deep digit register.
- Time-multiplexes the digits onto a common-bus seven-segment display, with optional leading-zero blanking.
- All outputs are registered; a parameterised refresh prescaler sets the scan rate.

---
 rtl/hex_display_scanner.sv | 135 +++++++++++++
 tb/tb_hex_display_scanner.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_display_scanner.sv
// Purpose : shifts captured 4-bit nibbles into a digit register and time-multiplexes them onto a common-bus 7-segment display.
// Latency : a change to the digit register or scan index reaches an/seg/dp on the following clk edge (all outputs registered).
// Backpressure: none; nibble_valid is accepted every cycle unless freeze is high, and scanning never stalls.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   nibble_in         value shifted into digit 0 when nibble_valid && !freeze
//   nibble_valid      capture strobe
//   clear             synchronous clear of all digits (beats nibble_valid)
//   freeze            ignore nibble_valid; scanning continues
//   blank_lz          enable leading-zero blanking
//   dp_in             per-digit decimal-point request
//   an                one-hot digit select (ACTIVE_LOW_AN polarity)
//   seg               segments {g,f,e,d,c,b,a} (ACTIVE_LOW_SEG polarity)
//   dp                decimal point of the selected digit (ACTIVE_LOW_SEG polarity)
module hex_display_scanner #(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter bit ACTIVE_LOW_SEG = 1'b1,
  parameter bit ACTIVE_LOW_AN  = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            nibble_in,
  input  logic                  nibble_valid,
  input  logic                  clear,
  input  logic                  freeze,
  input  logic                  blank_lz,
  input  logic [NUM_DIGITS-1:0] dp_in,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg,
  output logic                  dp
);

  // Keep counter widths at least one bit so REFRESH_DIV=1 / NUM_DIGITS=1 stay legal.
  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF   = ACTIVE_LOW_AN ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
  localparam logic [6:0]            SEG_OFF  = ACTIVE_LOW_SEG ? 7'h7F : 7'h00;
  localparam logic                  DP_OFF   = ACTIVE_LOW_SEG;

  logic [3:0]            digits [NUM_DIGITS];
  logic [CNT_W-1:0]      presc_cnt;
  logic [IDX_W-1:0]      scan_idx;
  logic                  presc_wrap;

  logic [NUM_DIGITS:0]   zero_from;
  logic [3:0]            cur_digit;
  logic                  blank_cur;
  logic [6:0]            seg_hi;
  logic [NUM_DIGITS-1:0] an_hot;

  // Active-high hex font, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    s = 7'h00;
    case (v)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      4'hF: s = 7'h71;
    endcase
    return s;
  endfunction

  // Digit shift register: clear has priority over capture; freeze only gates capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_DIGITS; i++) digits[i] <= 4'h0;
    end else if (clear) begin
      for (int i = 0; i < NUM_DIGITS; i++) digits[i] <= 4'h0;
    end else if (nibble_valid && !freeze) begin
      for (int i = NUM_DIGITS - 1; i > 0; i--) digits[i] <= digits[i-1];
      digits[0] <= nibble_in;
    end
  end

  assign presc_wrap = (presc_cnt == CNT_LAST);

  // Refresh prescaler and scan index run freely, independent of capture controls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_cnt <= '0;
      scan_idx  <= '0;
    end else if (presc_wrap) begin
      presc_cnt <= '0;
      scan_idx  <= (scan_idx == IDX_LAST) ? '0 : scan_idx + IDX_W'(1);
    end else begin
      presc_cnt <= presc_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    // zero_from[i] is set when digits i..NUM_DIGITS-1 are all zero.
    zero_from             = '0;
    zero_from[NUM_DIGITS] = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_from[i] = zero_from[i+1] && (digits[i] == 4'h0);
    end
    cur_digit = digits[scan_idx];
    // Digit 0 is never blanked so an all-zero value still shows "0".
    blank_cur = blank_lz && (scan_idx != '0) && zero_from[scan_idx];
    seg_hi    = blank_cur ? 7'h00 : hex_to_seg(cur_digit);
    an_hot    = NUM_DIGITS'(1) << scan_idx;
  end

  // Registered output stage; reset forces every output to its inactive level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an  <= AN_OFF;
      seg <= SEG_OFF;
      dp  <= DP_OFF;
    end else begin
      an  <= ACTIVE_LOW_AN ? ~an_hot : an_hot;
      seg <= ACTIVE_LOW_SEG ? ~seg_hi : seg_hi;
      dp  <= dp_in[scan_idx] ^ ACTIVE_LOW_SEG;
    end
  end

endmodule

// File: tb/tb_hex_display_scanner.sv
// Bench for hex_display_scanner: two instances (REFRESH_DIV=4 and REFRESH_DIV=1) share stimulus.
// Expected digit slots (an/seg/dp plus the cycle they must appear on) are queued by the stimulus;
// a forked monitor pops and compares whenever an instance changes its anode select.
module tb_hex_display_scanner;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    int         cyc;
  } exp_t;

  logic       clk;
  logic       reset;
  logic [3:0] nibble_in;
  logic       nibble_valid;
  logic       clear;
  logic       freeze;
  logic       blank_lz;
  logic [3:0] dp_in;
  logic [3:0] an0, an1;
  logic [6:0] seg0, seg1;
  logic       dp0, dp1;

  int   checks;
  int   failures;
  int   cyc;
  int   guard;
  logic en0, en1;
  logic [3:0] prev_an0, prev_an1;
  exp_t q0[$];
  exp_t q1[$];

  hex_display_scanner #(.NUM_DIGITS(4), .REFRESH_DIV(4), .ACTIVE_LOW_SEG(1'b1), .ACTIVE_LOW_AN(1'b1)) dut0 (
    .clk(clk), .reset(reset), .nibble_in(nibble_in), .nibble_valid(nibble_valid),
    .clear(clear), .freeze(freeze), .blank_lz(blank_lz), .dp_in(dp_in),
    .an(an0), .seg(seg0), .dp(dp0)
  );

  hex_display_scanner #(.NUM_DIGITS(4), .REFRESH_DIV(1), .ACTIVE_LOW_SEG(1'b1), .ACTIVE_LOW_AN(1'b1)) dut1 (
    .clk(clk), .reset(reset), .nibble_in(nibble_in), .nibble_valid(nibble_valid),
    .clear(clear), .freeze(freeze), .blank_lz(blank_lz), .dp_in(dp_in),
    .an(an1), .seg(seg1), .dp(dp1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edges seen since reset released; expected slots are pinned to these numbers.
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic mon_step();
    exp_t e;
    if (en0 && (an0 !== prev_an0)) begin
      checks++;
      if (q0.size() == 0) begin
        failures++;
        $display("FAIL scan_div4 unexpected output an=%b seg=%h dp=%b cyc=%0d", an0, seg0, dp0, cyc);
      end else begin
        e = q0.pop_front();
        if (an0 !== e.an || seg0 !== e.seg || dp0 !== e.dp || cyc != e.cyc) begin
          failures++;
          $display("FAIL scan_div4 got an=%b seg=%h dp=%b cyc=%0d expected an=%b seg=%h dp=%b cyc=%0d",
                   an0, seg0, dp0, cyc, e.an, e.seg, e.dp, e.cyc);
        end
      end
    end
    prev_an0 = an0;
    if (en1 && (an1 !== prev_an1)) begin
      checks++;
      if (q1.size() == 0) begin
        failures++;
        $display("FAIL scan_div1 unexpected output an=%b seg=%h dp=%b cyc=%0d", an1, seg1, dp1, cyc);
      end else begin
        e = q1.pop_front();
        if (an1 !== e.an || seg1 !== e.seg || dp1 !== e.dp || cyc != e.cyc) begin
          failures++;
          $display("FAIL scan_div1 got an=%b seg=%h dp=%b cyc=%0d expected an=%b seg=%h dp=%b cyc=%0d",
                   an1, seg1, dp1, cyc, e.an, e.seg, e.dp, e.cyc);
        end
      end
    end
    prev_an1 = an1;
  endtask

  // Wait (bounded) until the monitor has consumed every queued slot, then disable it.
  task automatic wait_drain(input int inst, input int budget);
    for (int k = 0; k < budget; k++) begin
      @(posedge clk);
      if ((inst == 0 && q0.size() == 0) || (inst == 1 && q1.size() == 0)) break;
    end
    if ((inst == 0 && q0.size() != 0) || (inst == 1 && q1.size() != 0)) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout inst=%0d pending=%0d required=0", inst, (inst == 0) ? q0.size() : q1.size());
      if (inst == 0) q0.delete(); else q1.delete();
    end
    if (inst == 0) en0 = 1'b0; else en1 = 1'b0;
    @(negedge clk);
  endtask

  // Queue nslots consecutive digit slots starting at the next anode change.
  // s0..s3 are hand-computed active-high segment patterns for digits 0..3 (00 = blank).
  task automatic expect_scan(input int inst, input int nslots,
                             input logic [6:0] s0, input logic [6:0] s1,
                             input logic [6:0] s2, input logic [6:0] s3);
    logic [6:0] s [4];
    int   rd, n, idx;
    exp_t e;
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
    #1;
    rd = (inst == 0) ? 4 : 1;
    n  = ((cyc + rd - 1) / rd) * rd + 1;
    for (int k = 0; k < nslots; k++) begin
      idx   = ((n - 1) / rd) % 4;
      e.an  = ~(4'b0001 << idx);
      e.seg = ~s[idx];
      e.dp  = ~dp_in[idx];
      e.cyc = n;
      if (inst == 0) q0.push_back(e); else q1.push_back(e);
      n += rd;
    end
    if (inst == 0) en0 = 1'b1; else en1 = 1'b1;
    wait_drain(inst, nslots * rd + 8);
  endtask

  task automatic load(input logic [3:0] v);
    nibble_in    = v;
    nibble_valid = 1'b1;
    @(negedge clk);
    nibble_valid = 1'b0;
  endtask

  initial begin
    exp_t r;
    checks       = 0;
    failures     = 0;
    en0          = 1'b0;
    en1          = 1'b0;
    prev_an0     = 4'b0000;
    prev_an1     = 4'b0000;
    reset        = 1'b0;
    nibble_in    = 4'h0;
    nibble_valid = 1'b0;
    clear        = 1'b0;
    freeze       = 1'b0;
    blank_lz     = 1'b0;
    dp_in        = 4'b0000;

    fork
      forever begin
        @(negedge clk);
        mon_step();
      end
    join_none

    // Outputs inactive while reset is held.
    r.an = 4'b1111; r.seg = 7'h7F; r.dp = 1'b1; r.cyc = 0;
    q0.push_back(r);
    q1.push_back(r);
    en0 = 1'b1;
    en1 = 1'b1;
    #2 reset = 1'b1;
    repeat (2) @(negedge clk);
    wait_drain(0, 4);
    wait_drain(1, 4);
    reset = 1'b0;

    // First edge after release selects digit 0, then rotate every 4 cycles.
    expect_scan(0, 5, 7'h3F, 7'h3F, 7'h3F, 7'h3F);

    // 1,2,3,4 -> digit0=4 ... digit3=1.
    for (int v = 1; v <= 4; v++) load(4'(v));
    expect_scan(0, 4, 7'h66, 7'h4F, 7'h5B, 7'h06);

    // Five nibbles: oldest dropped -> {5,4,3,2}; frozen capture of 9 is ignored.
    for (int v = 1; v <= 5; v++) load(4'(v));
    expect_scan(0, 4, 7'h6D, 7'h66, 7'h4F, 7'h5B);
    freeze = 1'b1;
    load(4'h9);
    freeze = 1'b0;
    expect_scan(0, 4, 7'h6D, 7'h66, 7'h4F, 7'h5B);
    expect_scan(1, 4, 7'h6D, 7'h66, 7'h4F, 7'h5B);

    // Leading-zero blanking.
    clear = 1'b1;
    @(negedge clk);
    clear    = 1'b0;
    blank_lz = 1'b1;
    expect_scan(0, 4, 7'h3F, 7'h00, 7'h00, 7'h00);
    load(4'h0); load(4'h0); load(4'h7);
    expect_scan(0, 4, 7'h07, 7'h00, 7'h00, 7'h00);
    load(4'h0);
    expect_scan(0, 4, 7'h3F, 7'h07, 7'h00, 7'h00);
    load(4'h5);
    expect_scan(0, 4, 7'h6D, 7'h3F, 7'h07, 7'h00);

    // clear beats nibble_valid on the same edge.
    blank_lz     = 1'b0;
    clear        = 1'b1;
    nibble_in    = 4'h8;
    nibble_valid = 1'b1;
    @(negedge clk);
    clear        = 1'b0;
    nibble_valid = 1'b0;
    expect_scan(0, 4, 7'h3F, 7'h3F, 7'h3F, 7'h3F);

    // Hex letters, then reset asserted between clock edges while digit 2 is shown.
    load(4'hA); load(4'hB); load(4'hC); load(4'hD);
    expect_scan(0, 4, 7'h5E, 7'h39, 7'h7C, 7'h77);
    guard = 0;
    while (!((cyc >= 1) && (((cyc - 1) / 4) % 4 == 2) && ((cyc - 1) % 4 == 1)) && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 64) begin
      checks++;
      failures++;
      $display("FAIL mid_scan_wait guard=%0d required<64", guard);
    end
    r.an = 4'b1111; r.seg = 7'h7F; r.dp = 1'b1; r.cyc = 0;
    q0.push_back(r);
    en0 = 1'b1;
    @(posedge clk);
    #1 reset = 1'b1;
    wait_drain(0, 4);
    @(negedge clk);
    reset = 1'b0;
    expect_scan(0, 4, 7'h3F, 7'h3F, 7'h3F, 7'h3F);

    // REFRESH_DIV=1 scans every cycle; dp only on digit 2.
    for (int v = 1; v <= 4; v++) load(4'(v));
    dp_in = 4'b0100;
    expect_scan(1, 5, 7'h66, 7'h4F, 7'h5B, 7'h06);
    expect_scan(0, 4, 7'h66, 7'h4F, 7'h5B, 7'h06);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
